count_sched: RTL and testbench

- Round-robin scheduler that shares one `count` engine (W-bit ones/zeros counter) among N requesters.
- Each job is arbitrated, launched with a one-cycle start pulse, and its data/mode are held stable until the engine reports done.
- The result (or an error) is returned to the winning requester.
- Sits between client blocks and the single `count` instance.

---
 rtl/count_sched_pkg.sv | 13 +
 rtl/count_sched_arb.sv | 31 +++
 rtl/count_sched.sv | 154 +++++++++++++++
 tb/tb_count_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared mode codes, FSM states and helpers for count_sched
package count_sched_pkg;

  localparam logic [1:0] SEL_ONES  = 2'b10;
  localparam logic [1:0] SEL_ZEROS = 2'b01;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  function automatic logic sel_valid(input logic [1:0] sel);
    return (sel == SEL_ONES) || (sel == SEL_ZEROS);
  endfunction

endpackage

// File: rtl/count_sched_arb.sv
// rtl/count_sched_arb.sv - combinational round-robin pick: first set req bit at or after ptr
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx
);

  logic found;
  int   j;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// rtl/count_sched.sv - shares one count engine among N requesters, round-robin,
// with stale-done filtering and a WAIT timeout that returns an error response.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_data,
  input  logic [2*N-1:0]   req_sel,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     resp_valid,
  output logic [W-1:0]     resp_cnt,
  output logic             resp_err,
  output logic             eng_start,
  output logic [W-1:0]     eng_a_in,
  output logic [1:0]       eng_sel,
  input  logic             eng_done,
  input  logic [W-1:0]     eng_cntout
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_d;
  logic [IW-1:0] rr_ptr, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [TW-1:0] timer, timer_d;
  logic          done_q;

  logic [N-1:0]  gnt_d, rv_d;
  logic [W-1:0]  cnt_d, a_d;
  logic [1:0]    sel_d;
  logic          err_d, start_d;

  logic [N-1:0]  arb_win;
  logic [IW-1:0] arb_idx;
  logic [N-1:0]  win_oh;

  logic [W-1:0]  data_arr [N];
  logic [1:0]    sel_arr  [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign data_arr[i] = req_data[i*W +: W];
    assign sel_arr[i]  = req_sel[2*i +: 2];
  end

  rr_arb #(.N(N), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .win     (arb_win),
    .win_idx (arb_idx)
  );

  assign win_oh = {{(N-1){1'b0}}, 1'b1} << win_q;

  always_comb begin
    state_d = state;
    ptr_d   = rr_ptr;
    win_d   = win_q;
    timer_d = timer;
    gnt_d   = '0;
    rv_d    = '0;
    start_d = 1'b0;
    cnt_d   = resp_cnt;
    err_d   = resp_err;
    a_d     = eng_a_in;
    sel_d   = eng_sel;
    case (state)
      IDLE: begin
        if (|req) begin
          win_d = arb_idx;
          gnt_d = arb_win;
          a_d   = data_arr[arb_idx];
          sel_d = sel_arr[arb_idx];
          if (sel_valid(sel_arr[arb_idx])) begin
            state_d = LAUNCH;
            start_d = 1'b1;
          end else begin
            state_d = RESP;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer + 1'b1;
        // Only a rising done counts; a level left high from a previous job is ignored.
        if (eng_done && !done_q) begin
          cnt_d   = eng_cntout;
          err_d   = 1'b0;
          rv_d    = win_oh;
          state_d = RESP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          rv_d    = win_oh;
          state_d = RESP;
        end
      end
      RESP: begin
        // Entering RESP without a pending response means the invalid-sel path:
        // hold one extra cycle so the response trails the grant.
        if (|resp_valid) begin
          state_d = IDLE;
          err_d   = 1'b0;
          ptr_d   = (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
        end else begin
          rv_d  = win_oh;
          err_d = 1'b1;
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_q      <= '0;
      timer      <= '0;
      done_q     <= 1'b0;
      gnt        <= '0;
      resp_valid <= '0;
      resp_cnt   <= '0;
      resp_err   <= 1'b0;
      eng_start  <= 1'b0;
      eng_a_in   <= '0;
      eng_sel    <= 2'b00;
    end else begin
      state      <= state_d;
      rr_ptr     <= ptr_d;
      win_q      <= win_d;
      timer      <= timer_d;
      done_q     <= eng_done;
      gnt        <= gnt_d;
      resp_valid <= rv_d;
      resp_cnt   <= cnt_d;
      resp_err   <= err_d;
      eng_start  <= start_d;
      eng_a_in   <= a_d;
      eng_sel    <= sel_d;
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - directed bench for count_sched; the bench plays the count engine.
module tb_count_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  req_sel;
  logic [3:0]  gnt;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_cnt;
  logic        resp_err;
  logic        eng_start;
  logic [7:0]  eng_a_in;
  logic [1:0]  eng_sel;
  logic        eng_done;
  logic [7:0]  eng_cntout;

  int n_assert;
  int n_fail;
  int start_cnt;
  int s0;
  int t;

  count_sched #(.N(4), .W(8), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_sel    (req_sel),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_cnt   (resp_cnt),
    .resp_err   (resp_err),
    .eng_start  (eng_start),
    .eng_a_in   (eng_a_in),
    .eng_sel    (eng_sel),
    .eng_done   (eng_done),
    .eng_cntout (eng_cntout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (eng_start) start_cnt++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int w;
    w = 0;
    while (gnt == 4'b0000 && w < 20) begin
      cyc();
      w++;
    end
    chk({tag, "_gnt_seen"}, 32'(gnt != 4'b0000), 32'h1);
  endtask

  task automatic job(input logic [3:0] g, input logic [7:0] d, input logic [7:0] cnt,
                     input bit drop, input string tag);
    wait_gnt(tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'(g));
    chk({tag, "_a_in"}, 32'(eng_a_in), 32'(d));
    if (drop) req = req & ~g;
    cyc();
    cyc();
    eng_done   = 1'b1;
    eng_cntout = cnt;
    cyc();
    eng_done = 1'b0;
    chk({tag, "_rv"}, 32'(resp_valid), 32'(g));
    chk({tag, "_cnt"}, 32'(resp_cnt), 32'(cnt));
    chk({tag, "_err"}, 32'(resp_err), 32'h0);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    req        = 4'b0000;
    req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    req_sel    = 8'b10_10_10_10;
    eng_done   = 1'b0;
    eng_cntout = 8'h00;
    cyc(); cyc(); cyc();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rv", 32'(resp_valid), 32'h0);
    chk("rst_start", 32'(eng_start), 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_cnt", 32'(resp_cnt), 32'h0);
    chk("rst_a_in", 32'(eng_a_in), 32'h0);
    chk("rst_sel", 32'(eng_sel), 32'h0);
    rst = 1'b1;
    cyc();

    // Round robin with all four requesting continuously, starting from pointer 0.
    req = 4'b1111;
    job(4'b0001, 8'h11, 8'h01, 1'b0, "rr0");
    job(4'b0010, 8'h22, 8'h02, 1'b0, "rr1");
    job(4'b0100, 8'h33, 8'h03, 1'b0, "rr2");
    job(4'b1000, 8'h44, 8'h04, 1'b0, "rr3");
    job(4'b0001, 8'h11, 8'h05, 1'b0, "rr4");
    req = 4'b0100;
    job(4'b0100, 8'h33, 8'h07, 1'b1, "rr_only2");

    // Single job on requester 0: done three cycles after the start pulse.
    req_data[7:0] = 8'b0000_1011;
    req_sel[1:0]  = 2'b10;
    req = 4'b0001;
    s0  = start_cnt;
    cyc();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_start", 32'(eng_start), 32'h1);
    chk("single_a_in", 32'(eng_a_in), 32'h0B);
    chk("single_sel", 32'(eng_sel), 32'h2);
    req = 4'b0000;
    cyc();
    chk("single_gnt_off", 32'(gnt), 32'h0);
    chk("single_start_off", 32'(eng_start), 32'h0);
    cyc();
    cyc();
    chk("single_a_in_wait", 32'(eng_a_in), 32'h0B);
    eng_done   = 1'b1;
    eng_cntout = 8'd3;
    cyc();
    eng_done = 1'b0;
    chk("single_rv", 32'(resp_valid), 32'h1);
    chk("single_cnt", 32'(resp_cnt), 32'h3);
    chk("single_err", 32'(resp_err), 32'h0);
    chk("single_a_in_resp", 32'(eng_a_in), 32'h0B);
    cyc();
    chk("single_rv_off", 32'(resp_valid), 32'h0);
    chk("single_start_pulses", 32'(start_cnt - s0), 32'h1);

    // Invalid mode on requester 1: no engine start, error response after the grant.
    req_sel[3:2] = 2'b11;
    req = 4'b0010;
    s0  = start_cnt;
    cyc();
    chk("inv_gnt", 32'(gnt), 32'h2);
    chk("inv_start", 32'(eng_start), 32'h0);
    chk("inv_rv_early", 32'(resp_valid), 32'h0);
    req = 4'b0000;
    cyc();
    chk("inv_rv", 32'(resp_valid), 32'h2);
    chk("inv_err", 32'(resp_err), 32'h1);
    chk("inv_cnt", 32'(resp_cnt), 32'h0);
    chk("inv_gnt_off", 32'(gnt), 32'h0);
    cyc();
    chk("inv_rv_off", 32'(resp_valid), 32'h0);
    chk("inv_no_start", 32'(start_cnt - s0), 32'h0);
    req_sel[3:2] = 2'b10;

    // Stale done: level-high done before the job, real rising edge five cycles after start.
    req_sel[5:4] = 2'b01;
    eng_done     = 1'b1;
    eng_cntout   = 8'd6;
    cyc();
    req = 4'b0100;
    cyc();
    chk("stale_gnt", 32'(gnt), 32'h4);
    chk("stale_sel", 32'(eng_sel), 32'h1);
    req = 4'b0000;
    cyc();
    chk("stale_rv_w1", 32'(resp_valid), 32'h0);
    cyc();
    chk("stale_rv_w2", 32'(resp_valid), 32'h0);
    eng_done = 1'b0;
    cyc();
    cyc();
    cyc();
    eng_done = 1'b1;
    chk("stale_rv_w5", 32'(resp_valid), 32'h0);
    cyc();
    eng_done = 1'b0;
    chk("stale_rv", 32'(resp_valid), 32'h4);
    chk("stale_cnt", 32'(resp_cnt), 32'h6);
    chk("stale_err", 32'(resp_err), 32'h0);
    cyc();

    // Timeout on requester 3 with requester 0 queued behind it.
    req_data[7:0] = 8'h5A;
    req = 4'b1001;
    wait_gnt("to");
    chk("to_gnt", 32'(gnt), 32'h8);
    req = 4'b0001;
    t = 0;
    while (resp_valid == 4'b0000 && t < 100) begin
      cyc();
      t++;
    end
    chk("to_latency", 32'(t), 32'd65);
    chk("to_rv", 32'(resp_valid), 32'h8);
    chk("to_err", 32'(resp_err), 32'h1);
    chk("to_cnt", 32'(resp_cnt), 32'h0);
    cyc();
    job(4'b0001, 8'h5A, 8'h05, 1'b1, "to_next");

    // Asynchronous reset in the middle of WAIT, requester 3 pending.
    req = 4'b0010;
    wait_gnt("mid");
    chk("mid_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    cyc();
    cyc();
    req = 4'b1000;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_rv", 32'(resp_valid), 32'h0);
    chk("arst_start", 32'(eng_start), 32'h0);
    chk("arst_cnt", 32'(resp_cnt), 32'h0);
    chk("arst_a_in", 32'(eng_a_in), 32'h0);
    chk("arst_sel", 32'(eng_sel), 32'h0);
    cyc();
    chk("arst_rv_hold", 32'(resp_valid), 32'h0);
    rst = 1'b1;
    job(4'b1000, 8'h44, 8'h09, 1'b1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
